auto_jogador: RTL and testbench
===============================

# auto_jogador

Hardware player for the memory game (`circuito_exp7`), sitting on the other side of its `botoes`/`leds` interface. It starts a match, captures the first play the game shows on `leds`, and replays the growing sequence on `botoes`, appending a pseudo-random one-hot play after each round. It replaces the hand-written stimulus loop with a synthesizable block, so the game can be exercised on the board without a human player.

## Interface

Parameters:
- PRESS_CYCLES, 10: cycles each button stays asserted.
- GAP_CYCLES, 10: cycles of `botoes=0` after each press.
- START_CYCLES, 5: width of the `iniciar` pulse.
- SEED, 4'b1001: LFSR seed for new plays; must be nonzero.

Ports:
- clock, in, 1: single clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-low; the port keeps the codebase name `reset`.
- comecar, in, 1: level; sampled in INICIAL to start a match.
- leds, in, 4: game LED output.
- pronto, in, 1: game finished.
- ganhou, in, 1: game won.
- perdeu, in, 1: game lost.
- iniciar, out, 1: start pulse to the game.
- botoes, out, 4: one-hot button drive or 0.
- ativo, out, 1: high from leaving INICIAL until entering FIM.
- resultado, out, 2: 00 none, 01 won, 10 lost, 11 capture error.
- db_rodada, out, 4: current round index.
- db_jogada, out, 4: current play index inside the round.

## Operation

- Memory: 16×4 register array `seq`. LFSR: 4-bit, x^4+x^3+1, loaded with SEED on reset. New play = one-hot decode of `lfsr[1:0]`; the LFSR advances once per new play.
- FSM states and transitions:
  - INICIAL: leave when `comecar`=1.
  - PULSO_INICIAR: `iniciar`=1 for START_CYCLES.
  - ESPERA_LED: wait for `leds`≠0.
  - CAPTURA: if `leds` is one-hot, `seq[0]=leds`; otherwise `resultado`=11 and go to FIM.
  - ESPERA_APAGA: wait for `leds`=0.
  - PRESSIONA: `botoes=seq[jogada]`, PRESS_CYCLES.
  - SOLTA: `botoes`=0, GAP_CYCLES. Then:
    - if `jogada`<`rodada`: `jogada`++ and go to PRESSIONA;
    - else if `rodada`<15: go to NOVA_PRESSIONA;
    - else go to ESPERA_FIM.
  - NOVA_PRESSIONA: `seq[rodada+1]`=new play, `botoes`=new play, PRESS_CYCLES.
  - NOVA_SOLTA: GAP_CYCLES, then `rodada`++, `jogada`=0, go to PRESSIONA.
  - ESPERA_FIM: wait for `pronto`.
  - FIM: hold `resultado`; return to INICIAL when `comecar`=0.
- `pronto` seen in any state from PRESSIONA through ESPERA_FIM goes to FIM on the next cycle, with `botoes` forced to 0. `resultado` is taken from `ganhou`/`perdeu` sampled in that same cycle.
- `botoes` is a registered output: only one bit ever set, never glitching between presses.

## Timing

- Reset values: `iniciar`=0, `botoes`=0, `ativo`=0, `resultado`=00, `db_rodada`=0, `db_jogada`=0, state INICIAL, `seq` all zeros, LFSR=SEED.
- Reset asserted mid-press releases `botoes` immediately (asynchronous); no press resumes after reset is released.
- `iniciar` rises 1 cycle after `comecar` is sampled high.
- Each play costs exactly PRESS_CYCLES+GAP_CYCLES cycles. Round r costs (r+2)·(PRESS+GAP) cycles, or (r+1)·(PRESS+GAP) for r=15.
- The capture happens the first cycle `leds`≠0. There is no timeout: the block waits indefinitely.
- `pronto` arriving in the same cycle a press would start: the abort wins and `botoes` stays 0.

## Configuration

- AUTO_JOGADOR_PERDER_EN defined:
  - Adds input ports `rodada_perder[3:0]`, `jogada_perder[3:0]` and `botao_perder[3:0]`.
  - When `rodada`=`rodada_perder` and `jogada`=`jogada_perder`, one extra PRESSIONA/SOLTA pair driving `botao_perder` is inserted before the correct play.
  - The correct play is still issued afterwards if the game has not yet asserted `pronto`.
- Undefined: the ports are absent and the block always plays correctly.

## Structure

- Package `auto_jogador_pkg` holds:
  - the state enum;
  - `RESULT_NONE`/`RESULT_WON`/`RESULT_LOST`/`RESULT_ERR` encodings;
  - the one-hot decode function.
- One sub-module, `auto_jogador_temporizador`: a loadable down-counter with a `fim` flag, shared by all timed states.

## Test plan

- Capture then abort: reset low 1 cycle, `comecar`=1, game model shows `leds`=0001 then 0 → `iniciar` high 5 cycles, `seq[0]`=0001, first press `botoes`=0001 for 10 cycles; model then asserts `pronto` while the new play is pressed → `botoes`=0 next cycle, FIM.
- Full win: game model with 16 rounds → 136 replay presses plus 15 new plays, `ganhou` → `resultado`=01, `db_rodada`=15.
- PERDER_EN with `rodada_perder`=3, `jogada_perder`=2, `botao_perder`=0001: wrong press at round 3, play 2 → model asserts `perdeu` → `resultado`=10, `ativo`=0.
- Capture error: `leds`=0110 → `resultado`=11, no `botoes` activity.
- Reset asserted mid-PRESSIONA in round 5 → `botoes`=0 the same cycle, all outputs at reset values, restart works.
- LFSR with SEED=1001: the first three new plays match the precomputed one-hot values.

Source files
------------

// File: rtl/auto_jogador_pkg.sv
// rtl/auto_jogador_pkg.sv - shared states, result codes and play decoding for auto_jogador
package auto_jogador_pkg;

    typedef enum logic [3:0] {
        INICIAL,
        PULSO_INICIAR,
        ESPERA_LED,
        CAPTURA,
        ESPERA_APAGA,
        PRESSIONA,
        SOLTA,
        NOVA_PRESSIONA,
        NOVA_SOLTA,
        ESPERA_FIM,
        FIM
    } estado_t;

    localparam logic [1:0] RESULT_NONE = 2'b00;
    localparam logic [1:0] RESULT_WON  = 2'b01;
    localparam logic [1:0] RESULT_LOST = 2'b10;
    localparam logic [1:0] RESULT_ERR  = 2'b11;

    localparam int TIMER_W = 8;

    function automatic logic [3:0] decodifica(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

    function automatic logic um_quente(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/auto_jogador_if.sv
// rtl/auto_jogador_if.sv - button/LED handshake between the automatic player and the game
interface auto_jogador_if;
    logic       iniciar;
    logic [3:0] botoes;
    logic [3:0] leds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;

    modport master (output iniciar, botoes, input leds, pronto, ganhou, perdeu);
    modport slave  (input iniciar, botoes, output leds, pronto, ganhou, perdeu);
endinterface

// File: rtl/auto_jogador_temporizador.sv
// rtl/auto_jogador_temporizador.sv - loadable down-counter shared by every timed state
module auto_jogador_temporizador
    import auto_jogador_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               carregar,
    input  logic [TIMER_W-1:0] valor,
    output logic               fim
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carregar) begin
            cnt_d = valor;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fim = (cnt_q == '0);

endmodule

// File: rtl/auto_jogador.sv
// rtl/auto_jogador.sv - automatic player for the memory game; AUTO_JOGADOR_PERDER_EN adds a deliberate wrong press
module auto_jogador
    import auto_jogador_pkg::*;
#(
    parameter int         PRESS_CYCLES = 10,
    parameter int         GAP_CYCLES   = 10,
    parameter int         START_CYCLES = 5,
    parameter logic [3:0] SEED         = 4'b1001
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          comecar,
    auto_jogador_if.master jogo,
    output logic          ativo,
    output logic [1:0]    resultado,
    output logic [3:0]    db_rodada,
    output logic [3:0]    db_jogada
`ifdef AUTO_JOGADOR_PERDER_EN
    ,
    input  logic [3:0]    rodada_perder,
    input  logic [3:0]    jogada_perder,
    input  logic [3:0]    botao_perder
`endif
);

    localparam logic [TIMER_W-1:0] T_PRESS = TIMER_W'(PRESS_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_GAP   = TIMER_W'(GAP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_START = TIMER_W'(START_CYCLES - 1);

    estado_t            estado_q, estado_d;
    logic               iniciar_q, iniciar_d;
    logic [3:0]         botoes_q, botoes_d;
    logic               ativo_q, ativo_d;
    logic [1:0]         resultado_q, resultado_d;
    logic [3:0]         rodada_q, rodada_d;
    logic [3:0]         jogada_q, jogada_d;
    logic [3:0]         lfsr_q, lfsr_d;
    logic               errado_q, errado_d;
    logic [3:0]         seq_q [16];
    logic [3:0]         seq_d [16];

    logic               carregar;
    logic [TIMER_W-1:0] valor;
    logic               fim;
    logic               inicia;
    logic               pos_erro;
    logic [3:0]         botao_erro;
    logic [3:0]         nova;

    auto_jogador_temporizador u_temporizador (
        .clock    (clock),
        .reset    (reset),
        .carregar (carregar),
        .valor    (valor),
        .fim      (fim)
    );

    always_comb begin
        estado_d    = estado_q;
        iniciar_d   = iniciar_q;
        botoes_d    = botoes_q;
        ativo_d     = ativo_q;
        resultado_d = resultado_q;
        rodada_d    = rodada_q;
        jogada_d    = jogada_q;
        lfsr_d      = lfsr_q;
        errado_d    = errado_q;
        seq_d       = seq_q;
        carregar    = 1'b0;
        valor       = '0;
        inicia      = 1'b0;
        nova        = decodifica(lfsr_q[1:0]);

        case (estado_q)
            INICIAL: if (comecar) begin
                estado_d    = PULSO_INICIAR;
                iniciar_d   = 1'b1;
                ativo_d     = 1'b1;
                resultado_d = RESULT_NONE;
                rodada_d    = 4'd0;
                jogada_d    = 4'd0;
                errado_d    = 1'b0;
                carregar    = 1'b1;
                valor       = T_START;
            end
            PULSO_INICIAR: if (fim) begin
                iniciar_d = 1'b0;
                estado_d  = ESPERA_LED;
            end
            ESPERA_LED: if (jogo.leds != 4'd0) begin
                seq_d[0] = jogo.leds;
                estado_d = CAPTURA;
            end
            CAPTURA: if (um_quente(seq_q[0])) begin
                estado_d = ESPERA_APAGA;
            end else begin
                resultado_d = RESULT_ERR;
                ativo_d     = 1'b0;
                estado_d    = FIM;
            end
            ESPERA_APAGA: if (jogo.leds == 4'd0) inicia = 1'b1;
            PRESSIONA: if (fim) begin
                botoes_d = 4'd0;
                estado_d = SOLTA;
                carregar = 1'b1;
                valor    = T_GAP;
            end
            SOLTA: if (fim) begin
                // after an inserted wrong press, the same index is replayed correctly
                if (errado_q) begin
                    inicia = 1'b1;
                end else if (jogada_q < rodada_q) begin
                    jogada_d = jogada_q + 4'd1;
                    inicia   = 1'b1;
                end else if (rodada_q != 4'd15) begin
                    seq_d[rodada_q + 4'd1] = nova;
                    botoes_d = nova;
                    lfsr_d   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
                    estado_d = NOVA_PRESSIONA;
                    carregar = 1'b1;
                    valor    = T_PRESS;
                end else begin
                    estado_d = ESPERA_FIM;
                end
            end
            NOVA_PRESSIONA: if (fim) begin
                botoes_d = 4'd0;
                estado_d = NOVA_SOLTA;
                carregar = 1'b1;
                valor    = T_GAP;
            end
            NOVA_SOLTA: if (fim) begin
                rodada_d = rodada_q + 4'd1;
                jogada_d = 4'd0;
                inicia   = 1'b1;
            end
            ESPERA_FIM: ;
            FIM: if (!comecar) estado_d = INICIAL;
            default: estado_d = INICIAL;
        endcase

`ifdef AUTO_JOGADOR_PERDER_EN
        pos_erro   = (rodada_d == rodada_perder) && (jogada_d == jogada_perder);
        botao_erro = botao_perder;
`else
        pos_erro   = 1'b0;
        botao_erro = 4'd0;
`endif

        if (inicia) begin
            estado_d = PRESSIONA;
            carregar = 1'b1;
            valor    = T_PRESS;
            if (pos_erro && !errado_q) begin
                botoes_d = botao_erro;
                errado_d = 1'b1;
            end else begin
                botoes_d = seq_q[jogada_d];
                errado_d = 1'b0;
            end
        end

        // game end overrides any press that would start this cycle
        if (jogo.pronto && (estado_q inside {PRESSIONA, SOLTA, NOVA_PRESSIONA, NOVA_SOLTA, ESPERA_FIM})) begin
            estado_d    = FIM;
            botoes_d    = 4'd0;
            ativo_d     = 1'b0;
            errado_d    = 1'b0;
            resultado_d = jogo.ganhou ? RESULT_WON : (jogo.perdeu ? RESULT_LOST : RESULT_NONE);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= INICIAL;
            iniciar_q   <= 1'b0;
            botoes_q    <= 4'd0;
            ativo_q     <= 1'b0;
            resultado_q <= RESULT_NONE;
            rodada_q    <= 4'd0;
            jogada_q    <= 4'd0;
            lfsr_q      <= SEED;
            errado_q    <= 1'b0;
            seq_q       <= '{default: 4'd0};
        end else begin
            estado_q    <= estado_d;
            iniciar_q   <= iniciar_d;
            botoes_q    <= botoes_d;
            ativo_q     <= ativo_d;
            resultado_q <= resultado_d;
            rodada_q    <= rodada_d;
            jogada_q    <= jogada_d;
            lfsr_q      <= lfsr_d;
            errado_q    <= errado_d;
            seq_q       <= seq_d;
        end
    end

    assign jogo.iniciar = iniciar_q;
    assign jogo.botoes  = botoes_q;
    assign ativo        = ativo_q;
    assign resultado    = resultado_q;
    assign db_rodada    = rodada_q;
    assign db_jogada    = jogada_q;

endmodule

// File: tb/tb_auto_jogador.sv
// tb/tb_auto_jogador.sv - directed scoreboard bench for auto_jogador driving a small game model
module tb_auto_jogador;
    import auto_jogador_pkg::*;

    localparam int P = 10;
    localparam int G = 10;
    localparam int S = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       comecar;
    logic       ativo;
    logic [1:0] resultado;
    logic [3:0] db_rodada;
    logic [3:0] db_jogada;
`ifdef AUTO_JOGADOR_PERDER_EN
    logic [3:0] rodada_perder = 4'd3;
    logic [3:0] jogada_perder = 4'd2;
    logic [3:0] botao_perder  = 4'b0001;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [3:0] exp_q [$];
    logic [3:0] game_seq [16];
    logic [3:0] lfsr_exp [3];

    auto_jogador_if jogo ();

    auto_jogador dut (
        .clock         (clock),
        .reset         (reset),
        .comecar       (comecar),
        .jogo          (jogo),
        .ativo         (ativo),
        .resultado     (resultado),
        .db_rodada     (db_rodada),
        .db_jogada     (db_jogada)
`ifdef AUTO_JOGADOR_PERDER_EN
        ,
        .rodada_perder (rodada_perder),
        .jogada_perder (jogada_perder),
        .botao_perder  (botao_perder)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (jogo.botoes == 4'd0 && lat < 500) begin
            @(negedge clock);
            lat++;
        end
        if (lat >= 500) chk("press_timeout", 32'(jogo.botoes != 4'd0), 32'd1);
    endtask

    task automatic measure(output logic [3:0] val, output int w);
        val = jogo.botoes;
        w   = 0;
        while (jogo.botoes == val && w < 500) begin
            w++;
            @(negedge clock);
        end
    endtask

    task automatic start_match(input logic [3:0] led);
        int lat;
        comecar = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!jogo.iniciar && lat < 50);
        chk("iniciar_latency", lat, 1);
        lat = 0;
        while (jogo.iniciar && lat < 50) begin
            lat++;
            @(negedge clock);
        end
        chk("iniciar_width", lat, S);
        jogo.leds   = led;
        game_seq[0] = led;
        repeat (3) @(negedge clock);
        jogo.leds = 4'd0;
    endtask

    task automatic end_match(input logic g, input logic p, input logic [1:0] res);
        jogo.ganhou = g;
        jogo.perdeu = p;
        jogo.pronto = 1'b1;
        @(negedge clock);
        chk("end_botoes", jogo.botoes, 4'd0);
        chk("end_ativo", ativo, 1'b0);
        chk("end_resultado", resultado, res);
        jogo.pronto = 1'b0;
        jogo.ganhou = 1'b0;
        jogo.perdeu = 1'b0;
        comecar     = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic play_round(input int r, input bit new_play, input bit chk_lfsr);
        int         lat;
        int         w;
        logic [3:0] val;
        for (int j = 0; j <= r; j++) exp_q.push_back(game_seq[j]);
        for (int j = 0; j <= r; j++) begin
            wait_start(lat);
            if (r > 0 || j > 0) chk("gap", lat, G);
            if (j == 0) chk("db_rodada", db_rodada, r);
            chk("db_jogada", db_jogada, j);
            measure(val, w);
            chk("replay", val, exp_q.pop_front());
            chk("press_width", w, P);
        end
        if (new_play) begin
            wait_start(lat);
            chk("gap_new", lat, G);
            measure(val, w);
            chk("new_onehot", 32'(um_quente(val)), 32'd1);
            chk("new_width", w, P);
            game_seq[r+1] = val;
            if (chk_lfsr && r < 3) chk($sformatf("lfsr_play_%0d", r + 1), val, lfsr_exp[r]);
        end
    endtask

    initial begin
        int         lat;
        int         w;
        logic [3:0] val;
        bit         seen;

        lfsr_exp[0] = 4'b0010;
        lfsr_exp[1] = 4'b1000;
        lfsr_exp[2] = 4'b0100;
        reset       = 1'b0;
        comecar     = 1'b0;
        jogo.leds   = 4'd0;
        jogo.pronto = 1'b0;
        jogo.ganhou = 1'b0;
        jogo.perdeu = 1'b0;

        @(negedge clock);
        chk("rst_iniciar", jogo.iniciar, 1'b0);
        chk("rst_botoes", jogo.botoes, 4'd0);
        chk("rst_ativo", ativo, 1'b0);
        chk("rst_resultado", resultado, RESULT_NONE);
        chk("rst_rodada", db_rodada, 4'd0);
        chk("rst_jogada", db_jogada, 4'd0);
        reset = 1'b1;
        @(negedge clock);

        // capture, first replay, then abort during the first new play
        start_match(4'b0001);
        chk("ativo_running", ativo, 1'b1);
        exp_q.push_back(4'b0001);
        wait_start(lat);
        measure(val, w);
        chk("t1_replay", val, exp_q.pop_front());
        chk("t1_width", w, P);
        wait_start(lat);
        chk("t1_gap", lat, G);
        chk("t1_new_play", jogo.botoes, 4'b0010);
        end_match(1'b0, 1'b1, RESULT_LOST);

        // capture error: two LEDs lit
        start_match(4'b0110);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (jogo.botoes != 4'd0) seen = 1'b1;
        end
        chk("err_no_press", 32'(seen), 32'd0);
        chk("err_resultado", resultado, RESULT_ERR);
        chk("err_ativo", ativo, 1'b0);
        comecar = 1'b0;
        repeat (3) @(negedge clock);

        // full 16-round win
        start_match(4'b0100);
        for (int r = 0; r < 16; r++) play_round(r, r < 15, 1'b0);
        chk("win_rodada", db_rodada, 4'd15);
        end_match(1'b1, 1'b0, RESULT_WON);
        chk("win_rodada_held", db_rodada, 4'd15);

        // reset in the middle of a round-5 press
        start_match(4'b0010);
        for (int r = 0; r < 5; r++) play_round(r, 1'b1, 1'b0);
        wait_start(lat);
        repeat (3) @(negedge clock);
        reset   = 1'b0;
        comecar = 1'b0;
        #1;
        chk("rst_mid_botoes", jogo.botoes, 4'd0);
        chk("rst_mid_iniciar", jogo.iniciar, 1'b0);
        chk("rst_mid_ativo", ativo, 1'b0);
        chk("rst_mid_resultado", resultado, RESULT_NONE);
        chk("rst_mid_rodada", db_rodada, 4'd0);
        chk("rst_mid_jogada", db_jogada, 4'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        seen  = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (jogo.botoes != 4'd0) seen = 1'b1;
        end
        chk("rst_no_resume", 32'(seen), 32'd0);
        start_match(4'b1000);
        for (int r = 0; r < 3; r++) play_round(r, 1'b1, 1'b1);
        end_match(1'b0, 1'b1, RESULT_LOST);

`ifdef AUTO_JOGADOR_PERDER_EN
        start_match(4'b0001);
        for (int r = 0; r < 3; r++) play_round(r, 1'b1, 1'b0);
        for (int j = 0; j < 2; j++) begin
            wait_start(lat);
            measure(val, w);
            chk("perder_pre", val, game_seq[j]);
        end
        wait_start(lat);
        chk("perder_jogada", db_jogada, 4'd2);
        measure(val, w);
        chk("perder_press", val, 4'b0001);
        end_match(1'b0, 1'b1, RESULT_LOST);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
